instr_fetch_unit: RTL and testbench

- Fetch stage directly upstream of the registered opcode decoder.
- Holds the PC and issues one-at-a-time word reads to instruction memory (variable latency).
- Presents the fetched 16-bit instruction, its opcode field, PC and PC+1 to decode with a valid/ready handshake.
- Accepts redirects (jump/branch taken) from the execute side and squashes any in-flight or held fetch.

---
 rtl/cpu_pkg.sv | 25 ++
 rtl/instr_fetch_unit.sv | 97 +++++++++
 tb/tb_instr_fetch_unit.sv | 273 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcode encodings, instruction field positions and
// the fetch-stage state encoding.
package cpu_pkg;

  localparam logic [2:0] OP_R    = 3'b000;
  localparam logic [2:0] OP_SLTI = 3'b001;
  localparam logic [2:0] OP_J    = 3'b010;
  localparam logic [2:0] OP_JAL  = 3'b011;
  localparam logic [2:0] OP_LW   = 3'b100;
  localparam logic [2:0] OP_SW   = 3'b101;
  localparam logic [2:0] OP_BEQ  = 3'b110;
  localparam logic [2:0] OP_ADDI = 3'b111;

  localparam int OPCODE_HI = 15;
  localparam int OPCODE_LO = 13;
  localparam int RD_HI     = 12;
  localparam int RD_LO     = 10;

  typedef enum logic [1:0] {
    FS_REQ  = 2'd0,
    FS_WAIT = 2'd1,
    FS_HOLD = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: owns the PC, issues one word read at a time to
// instruction memory and hands the fetched word to decode over valid/ready.
//
// state   | meaning
// --------+-----------------------------------------------------------
// FS_REQ  | drive imem_req for the current pc (one cycle)
// FS_WAIT | request outstanding; wait for imem_valid
// FS_HOLD | instruction held for decode until transfer or redirect
//
// A redirect while a request is outstanding cannot cancel it at the memory,
// so the discard flag marks the eventual response as stale.
module instr_fetch_unit
  import cpu_pkg::*;
#(
  parameter int              PC_W     = 16,
  parameter int              INSTR_W  = 16,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rst,
  output logic               imem_req,
  output logic [PC_W-1:0]    imem_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               imem_valid,
  output logic [INSTR_W-1:0] instr,
  output logic [2:0]         opcode,
  output logic [PC_W-1:0]    pc_out,
  output logic [PC_W-1:0]    pc_plus1,
  output logic               instr_valid,
  input  logic               instr_ready,
  input  logic               redirect,
  input  logic [PC_W-1:0]    redirect_target
);

  fetch_state_t    state;
  logic [PC_W-1:0] pc;
  logic            discard;

  // The state register resets into FS_REQ, so the request is gated with rst
  // to keep it low for as long as reset is held.
  assign imem_req    = rst & (state == FS_REQ);
  assign imem_addr   = pc;
  assign instr_valid = (state == FS_HOLD);
  assign pc_out      = pc;
  assign pc_plus1    = pc + PC_W'(1);
  assign opcode      = instr[INSTR_W-1 -: 3];

  // Fetch sequencer: state, pc, stale-response flag and the held instruction.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= FS_REQ;
      pc      <= RESET_PC;
      discard <= 1'b0;
      instr   <= '0;
    end else begin
      case (state)
        FS_REQ: begin
          state <= FS_WAIT;
          if (redirect) begin
            pc      <= redirect_target;
            discard <= 1'b1;
          end
        end
        FS_WAIT: begin
          if (!imem_valid) begin
            if (redirect) begin
              pc      <= redirect_target;
              discard <= 1'b1;
            end
          end else if (redirect) begin
            pc      <= redirect_target;
            discard <= 1'b0;
            state   <= FS_REQ;
          end else if (discard) begin
            discard <= 1'b0;
            state   <= FS_REQ;
          end else begin
            instr <= imem_rdata;
            state <= FS_HOLD;
          end
        end
        FS_HOLD: begin
          // Redirect wins over a simultaneous transfer; the held word is dropped.
          if (redirect) begin
            pc    <= redirect_target;
            state <= FS_REQ;
          end else if (instr_ready) begin
            pc    <= pc + PC_W'(1);
            state <= FS_REQ;
          end
        end
        default: state <= FS_REQ;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: behavioural instruction memory with adjustable
// latency, a scoreboard of expected decode transfers and directed scenarios.
module tb_instr_fetch_unit;
  import cpu_pkg::*;

  typedef struct packed {
    logic [15:0] instr;
    logic [2:0]  op;
    logic [15:0] pc;
    logic [15:0] pp1;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic [15:0] imem_rdata;
  logic        imem_valid;
  logic [15:0] instr;
  logic [2:0]  opcode;
  logic [15:0] pc_out;
  logic [15:0] pc_plus1;
  logic        instr_valid;
  logic        instr_ready;
  logic        redirect;
  logic [15:0] redirect_target;

  logic        mem_valid   = 1'b0;
  logic        stale_valid = 1'b0;
  logic [15:0] mem_rdata   = '0;
  logic [15:0] m_addr;
  int          m_gen;

  int n_pass = 0;
  int n_total = 0;
  int lat = 1;
  int gen = 0;
  int cyc = 0;
  logic [15:0] req_log[$];
  int          xfer_cyc[$];
  exp_t        sb[$];
  exp_t        mon_e;

  assign imem_valid = mem_valid | stale_valid;
  assign imem_rdata = stale_valid ? 16'hDEAD : mem_rdata;

  instr_fetch_unit #(.PC_W(16), .INSTR_W(16), .RESET_PC(16'h0000)) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata), .imem_valid(imem_valid),
    .instr(instr), .opcode(opcode), .pc_out(pc_out), .pc_plus1(pc_plus1),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .redirect(redirect), .redirect_target(redirect_target)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  function automatic logic [15:0] mem_rd(input logic [15:0] a);
    case (a)
      16'h0000: return 16'hE041;
      16'h0001: return 16'h8082;
      16'h0002: return 16'h4005;
      16'h0010: return 16'hC3F0;
      16'h0040: return 16'h6123;
      16'hFFFF: return 16'h2ABC;
      default:  return a ^ 16'h5A00;
    endcase
  endfunction

  function automatic logic [15:0] log_at(input int i);
    if (i < req_log.size()) return req_log[i];
    return 16'hxxxx;
  endfunction

  // Instruction memory: sample the request mid-cycle, answer `lat` cycles later
  // unless a reset has intervened.
  always begin
    @(negedge clk);
    if (rst && imem_req) begin
      m_addr = imem_addr;
      m_gen  = gen;
      req_log.push_back(m_addr);
      repeat (lat) @(posedge clk);
      #1;
      if (m_gen == gen && rst) begin
        mem_valid = 1'b1;
        mem_rdata = mem_rd(m_addr);
        @(posedge clk);
        #1;
        mem_valid = 1'b0;
      end
    end
  end

  // Monitor: every decode transfer is compared with the head of the scoreboard.
  always @(negedge clk) begin
    if (rst && instr_valid && instr_ready && !redirect) begin
      xfer_cyc.push_back(cyc);
      n_total++;
      if (sb.size() == 0) begin
        $display("FAIL xfer_unexpected actual instr=%h pc=%h required none", instr, pc_out);
      end else begin
        mon_e = sb.pop_front();
        if ({instr, opcode, pc_out, pc_plus1} === mon_e) n_pass++;
        else $display("FAIL xfer actual instr=%h op=%b pc=%h pp1=%h required instr=%h op=%b pc=%h pp1=%h",
                      instr, opcode, pc_out, pc_plus1, mon_e.instr, mon_e.op, mon_e.pc, mon_e.pp1);
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s actual=%h required=%h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [15:0] i, input logic [2:0] o, input logic [15:0] p, input logic [15:0] q);
    sb.push_back('{instr: i, op: o, pc: p, pp1: q});
  endtask

  task automatic wait_sb(input int budget, input string name);
    int i = 0;
    while (sb.size() != 0 && i < budget) begin
      tick();
      i++;
    end
    if (sb.size() != 0) begin
      n_total++;
      $display("FAIL %s actual=%0d pending required=0", name, sb.size());
      sb.delete();
    end
  endtask

  task automatic wait_valid(input int budget, input string name, output int n);
    n = 0;
    while (!instr_valid && n < budget) begin
      tick();
      n++;
    end
    if (!instr_valid) begin
      n_total++;
      $display("FAIL %s actual=no instr_valid required=instr_valid within %0d", name, budget);
    end
  endtask

  initial begin
    int n;
    logic ok;
    rst = 1'b0; instr_ready = 1'b1; redirect = 1'b0; redirect_target = '0;
    #3;
    check("rst_instr_valid", 32'(instr_valid), 32'd0);
    check("rst_imem_req",    32'(imem_req),    32'd0);
    check("rst_instr",       32'(instr),       32'd0);
    check("rst_opcode",      32'(opcode),      32'd0);
    check("rst_pc_out",      32'(pc_out),      32'd0);
    check("rst_pc_plus1",    32'(pc_plus1),    32'd1);
    check("rst_imem_addr",   32'(imem_addr),   32'd0);
    #3 rst = 1'b1;

    // Back-to-back fetch, latency 1, decode always ready.
    push(16'hE041, OP_ADDI, 16'h0000, 16'h0001);
    push(16'h8082, OP_LW,   16'h0001, 16'h0002);
    push(16'h4005, OP_J,    16'h0002, 16'h0003);
    wait_sb(40, "p1_drain");
    check("p1_addr0", 32'(log_at(0)), 32'h0);
    check("p1_addr1", 32'(log_at(1)), 32'h1);
    check("p1_addr2", 32'(log_at(2)), 32'h2);
    check("p1_spacing01", (xfer_cyc.size() >= 3) ? 32'(xfer_cyc[1] - xfer_cyc[0]) : 32'hFFFF, 32'd3);
    check("p1_spacing12", (xfer_cyc.size() >= 3) ? 32'(xfer_cyc[2] - xfer_cyc[1]) : 32'hFFFF, 32'd3);

    // Latency 4, decode stalled for 5 cycles in HOLD.
    instr_ready = 1'b0; lat = 4;
    check("p2_req_addr", 32'({imem_req, imem_addr}), {15'd0, 1'b1, 16'h0003});
    wait_valid(30, "p2_wait_valid", n);
    check("p2_latency", 32'(n), 32'd5);
    ok = 1'b1;
    repeat (5) begin
      tick();
      if (!(instr === 16'h5A03 && pc_out === 16'h0003 && instr_valid === 1'b1 && imem_req === 1'b0)) ok = 1'b0;
    end
    check("p2_hold_stable", 32'(ok), 32'd1);
    check("p2_opcode", 32'(opcode), 32'(OP_J));
    push(16'h5A03, OP_J, 16'h0003, 16'h0004);
    lat = 3; instr_ready = 1'b1;
    tick();
    check("p2_next_addr", 32'({imem_req, imem_addr}), {15'd0, 1'b1, 16'h0004});
    push(16'h5A04, OP_J, 16'h0004, 16'h0005);
    wait_sb(30, "p2_drain");
    check("p3_req5", 32'({imem_req, imem_addr}), {15'd0, 1'b1, 16'h0005});

    // Redirect in WAIT while mem[5] is still in flight.
    instr_ready = 1'b0;
    tick();
    redirect = 1'b1; redirect_target = 16'h0040;
    tick();
    redirect = 1'b0;
    n = 0; ok = 1'b1;
    while (!imem_req && n < 10) begin
      if (instr_valid) ok = 1'b0;
      tick();
      n++;
    end
    check("p3_no_valid", 32'(ok), 32'd1);
    check("p3_drop_cycles", 32'(n), 32'd2);
    check("p3_next_addr", 32'({imem_req, imem_addr}), {15'd0, 1'b1, 16'h0040});
    wait_valid(20, "p3_wait_valid", n);
    check("p3_instr",    32'(instr),    32'h6123);
    check("p3_opcode",   32'(opcode),   32'(OP_JAL));
    check("p3_pc_out",   32'(pc_out),   32'h0040);
    check("p3_pc_plus1", 32'(pc_plus1), 32'h0041);

    // Redirect in HOLD with decode ready in the same cycle.
    redirect = 1'b1; redirect_target = 16'h0010; instr_ready = 1'b1;
    tick();
    redirect = 1'b0; instr_ready = 1'b0;
    check("p4_valid_low", 32'(instr_valid), 32'd0);
    check("p4_next_addr", 32'({imem_req, imem_addr}), {15'd0, 1'b1, 16'h0010});
    wait_valid(20, "p4_wait_valid", n);
    push(16'hC3F0, OP_BEQ, 16'h0010, 16'h0011);
    instr_ready = 1'b1;
    tick();
    instr_ready = 1'b0;

    // Redirect in REQ to the last address, then wrap.
    redirect = 1'b1; redirect_target = 16'hFFFF;
    tick();
    redirect = 1'b0;
    wait_valid(30, "p5_wait_valid", n);
    check("p5_pc_out",   32'(pc_out),   32'hFFFF);
    check("p5_pc_plus1", 32'(pc_plus1), 32'h0000);
    push(16'h2ABC, OP_SLTI, 16'hFFFF, 16'h0000);
    instr_ready = 1'b1;
    tick();
    instr_ready = 1'b0;
    check("p5_wrap_addr", 32'({imem_req, imem_addr}), {15'd0, 1'b1, 16'h0000});
    wait_sb(5, "p5_drain");

    // Asynchronous reset in the middle of WAIT.
    tick();
    #2 rst = 1'b0; gen++;
    #1;
    check("p6_valid_in_rst", 32'(instr_valid), 32'd0);
    check("p6_req_in_rst",   32'(imem_req),    32'd0);
    check("p6_instr_in_rst", 32'(instr),       32'd0);
    repeat (5) @(posedge clk);
    #3 rst = 1'b1; stale_valid = 1'b1;
    #1;
    check("p6_first_addr", 32'({imem_req, imem_addr}), {15'd0, 1'b1, 16'h0000});
    @(posedge clk);
    #1 stale_valid = 1'b0;
    check("p6_stale_ignored", 32'({instr_valid, imem_req}), 32'd0);
    push(16'hE041, OP_ADDI, 16'h0000, 16'h0001);
    instr_ready = 1'b1;
    wait_sb(30, "p6_drain");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
